// File: rtl/mat_pkg.sv
// Shared constants, FSM state type and packed-element addressing for the mat_mult_seq engine.
package mat_pkg;

    localparam int MAT_N      = 4;
    localparam int MAT_ELEM_W = 8;
    localparam int MAT_ACC_W  = 18;
    localparam int MAT_VEC_W  = MAT_N * MAT_N * MAT_ELEM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mat_state_e;

    // Row-major packing puts element [0][0] in the top byte of the vector.
    function automatic logic [6:0] elem_off(input logic [1:0] row, input logic [1:0] col);
        logic [6:0] lin;
        lin = 7'(row) * 7'd4 + 7'(col);
        return (7'd15 - lin) * 7'd8;
    endfunction

endpackage

// File: rtl/mat_mult_seq_if.sv
// Operand and result valid/ready handshakes of the sequential matrix multiplier.
interface mat_mult_seq_if;

    logic                          in_valid;
    logic                          in_ready;
    logic [mat_pkg::MAT_VEC_W-1:0] a;
    logic [mat_pkg::MAT_VEC_W-1:0] b;
    logic                          out_valid;
    logic                          out_ready;
    logic [mat_pkg::MAT_VEC_W-1:0] res;
    logic                          busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, busy
    );

endinterface

// File: rtl/mat_mac.sv
// Unsigned multiply-accumulate: exposes acc + a*b combinationally so the caller can
// capture the final sum of a dot product in the same cycle the last product arrives.
module mat_mac #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [ELEM_W-1:0] a_i,
    input  logic [ELEM_W-1:0] b_i,
    output logic [ACC_W-1:0]  sum_next
);

    logic [2*ELEM_W-1:0] prod_s;
    logic [ACC_W-1:0]    acc_d;
    logic [ACC_W-1:0]    acc_q;

    // Product and running sum, widened so no carry is lost.
    always_comb begin
        prod_s   = {{ELEM_W{1'b0}}, a_i} * {{ELEM_W{1'b0}}, b_i};
        sum_next = acc_q + {{(ACC_W-2*ELEM_W){1'b0}}, prod_s};
    end

    // Clear wins over enable so the last term of a dot product also restarts the sum.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = {ACC_W{1'b0}};
        end else if (en) begin
            acc_d = sum_next;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {ACC_W{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential 4x4 8-bit matrix multiply Res = A*B through one shared MAC, 64 cycles per product.
// Optional build macro MAT_SAT_EN: saturate each element at 255 instead of wrapping mod 256.
module mat_mult_seq
    import mat_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mat_mult_seq_if.slave  bus
);

    mat_state_e             state_q, state_d;
    logic [1:0]             i_q, i_d;
    logic [1:0]             j_q, j_d;
    logic [1:0]             k_q, k_d;
    logic [MAT_VEC_W-1:0]   a_q, a_d;
    logic [MAT_VEC_W-1:0]   b_q, b_d;
    logic [MAT_VEC_W-1:0]   res_q, res_d;

    logic [6:0]             a_off_s;
    logic [6:0]             b_off_s;
    logic [6:0]             res_off_s;
    logic [MAT_ELEM_W-1:0]  mac_a_s;
    logic [MAT_ELEM_W-1:0]  mac_b_s;
    logic [MAT_ACC_W-1:0]   mac_sum_s;
    logic [MAT_ELEM_W-1:0]  elem_s;
    logic                   mac_clr_s;
    logic                   mac_en_s;

    mat_mac #(
        .ELEM_W (MAT_ELEM_W),
        .ACC_W  (MAT_ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr_s),
        .en       (mac_en_s),
        .a_i      (mac_a_s),
        .b_i      (mac_b_s),
        .sum_next (mac_sum_s)
    );

    // Operand fetch from the captured copies: A[i][k] and B[k][j]; result lands at [i][j].
    always_comb begin
        a_off_s   = elem_off(i_q, k_q);
        b_off_s   = elem_off(k_q, j_q);
        res_off_s = elem_off(i_q, j_q);
        mac_a_s   = a_q[a_off_s +: MAT_ELEM_W];
        mac_b_s   = b_q[b_off_s +: MAT_ELEM_W];
    end

    // Reduce the 18-bit dot product to one result element.
    always_comb begin
`ifdef MAT_SAT_EN
        if (mac_sum_s > 18'd255) begin
            elem_s = 8'hFF;
        end else begin
            elem_s = mac_sum_s[MAT_ELEM_W-1:0];
        end
`else
        elem_s = mac_sum_s[MAT_ELEM_W-1:0];
`endif
    end

    // Next-state, loop counters, operand capture and element write-back.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        mac_clr_s = 1'b0;
        mac_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    i_d       = 2'd0;
                    j_d       = 2'd0;
                    k_d       = 2'd0;
                    mac_clr_s = 1'b1;
                    state_d   = CALC;
                end else begin
                    state_d   = IDLE;
                end
            end
            CALC: begin
                mac_en_s = 1'b1;
                k_d      = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    mac_clr_s                       = 1'b1;
                    res_d[res_off_s +: MAT_ELEM_W]  = elem_s;
                    j_d                             = j_q + 2'd1;
                    if (j_q == 2'd3) begin
                        i_d = i_q + 2'd1;
                        if (i_q == 2'd3) begin
                            state_d = DONE;
                        end else begin
                            state_d = CALC;
                        end
                    end else begin
                        i_d = i_q;
                    end
                end else begin
                    j_d = j_q;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and datapath registers; reset discards any product in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 2'd0;
            j_q     <= 2'd0;
            k_q     <= 2'd0;
            a_q     <= {MAT_VEC_W{1'b0}};
            b_q     <= {MAT_VEC_W{1'b0}};
            res_q   <= {MAT_VEC_W{1'b0}};
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // Handshake flags decode only from the state register.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == CALC) || (state_q == DONE);
    assign bus.res       = res_q;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed plus random stimulus for mat_mult_seq against an array-based matrix product model.
module tb_mat_mult_seq;
    import mat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_mult_seq_if bus_if ();

    mat_mult_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] v);
        logic [127:0] r;
        for (int e = 0; e < 16; e++) r[127-8*e -: 8] = v;
        return r;
    endfunction

    function automatic logic [127:0] small_rand();
        logic [127:0] r;
        for (int e = 0; e < 16; e++) r[127-8*e -: 8] = 8'($urandom_range(0, 15));
        return r;
    endfunction

    // Plain matrix product on integer arrays, then per-element wrap or saturate.
    function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
        int ma [4][4];
        int mb [4][4];
        int s;
        int v;
        logic [127:0] r;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++) begin
                ma[row][col] = int'(a[127-8*(4*row+col) -: 8]);
                mb[row][col] = int'(b[127-8*(4*row+col) -: 8]);
            end
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++) begin
                s = 0;
                for (int kk = 0; kk < 4; kk++) s += ma[row][kk] * mb[kk][col];
`ifdef MAT_SAT_EN
                v = (s > 255) ? 255 : s;
`else
                v = s % 256;
`endif
                r[127-8*(4*row+col) -: 8] = 8'(v);
            end
        return r;
    endfunction

    // Offer an operand pair for one edge, then scramble the bus inputs.
    task automatic start(input logic [127:0] a, input logic [127:0] b);
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.in_valid = 1'b1;
        check("in_ready_before_accept", 128'(bus_if.in_ready), 128'(1'b1));
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.a        = rand128();
        bus_if.b        = rand128();
        check("busy_after_accept", 128'(bus_if.busy), 128'(1'b1));
        check("in_ready_in_calc", 128'(bus_if.in_ready), 128'(1'b0));
    endtask

    // Edges after the accepting edge until out_valid; bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus_if.out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [127:0] a, input logic [127:0] b);
        int lat;
        logic [127:0] exp;
        exp = ref_mul(a, b);
        start(a, b);
        wait_done(lat);
        // out_valid first visible in cycle N+65, i.e. after 64 further edges.
        check({tag, "_latency"}, 128'(lat), 128'(64));
        check({tag, "_res"}, bus_if.res, exp);
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check({tag, "_in_ready_after"}, 128'(bus_if.in_ready), 128'(1'b1));
        check({tag, "_out_valid_after"}, 128'(bus_if.out_valid), 128'(1'b0));
    endtask

    initial begin
        logic [127:0] ident;
        logic [127:0] seq;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [127:0] exp;
        logic [127:0] res_snap;
        int lat;
        int saw_valid;

        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 128'(bus_if.in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(bus_if.out_valid), 128'(1'b0));
        check("rst_busy", 128'(bus_if.busy), 128'(1'b0));
        check("rst_res", bus_if.res, 128'(0));

        ident = '0;
        for (int d = 0; d < 4; d++) ident[127-8*(5*d) -: 8] = 8'h01;
        for (int e = 0; e < 16; e++) seq[127-8*e -: 8] = 8'(e + 1);
        run("identity", ident, seq);
        check("identity_is_b", ref_mul(ident, seq), seq);

        run("twos_threes", fill(8'h02), fill(8'h03));
        run("all_ff", fill(8'hFF), fill(8'hFF));
        run("ff_times_id", fill(8'hFF), ident);

        for (int t = 0; t < 3; t++) run("random", rand128(), rand128());
        run("small_random", small_rand(), small_rand());

        // Backpressure: result must hold and a stray in_valid must be ignored.
        ra  = rand128();
        rb  = rand128();
        exp = ref_mul(ra, rb);
        start(ra, rb);
        wait_done(lat);
        check("bp_latency", 128'(lat), 128'(64));
        res_snap = bus_if.res;
        check("bp_res_first", res_snap, exp);
        for (int t = 0; t < 10; t++) begin
            check("bp_res_stable", bus_if.res, exp);
            check("bp_in_ready_low", 128'(bus_if.in_ready), 128'(1'b0));
            check("bp_out_valid_high", 128'(bus_if.out_valid), 128'(1'b1));
            bus_if.in_valid = (t == 3);
            bus_if.a        = rand128();
            bus_if.b        = rand128();
            tick();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check("bp_in_ready_after", 128'(bus_if.in_ready), 128'(1'b1));
        tick();
        check("bp_no_ghost_busy", 128'(bus_if.busy), 128'(1'b0));

        // Reset 30 cycles into CALC discards the product silently.
        start(rand128(), rand128());
        for (int t = 0; t < 29; t++) tick();
        check("mid_busy", 128'(bus_if.busy), 128'(1'b1));
        rst = 1'b1;
        bus_if.out_ready = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.out_ready = 1'b0;
        check("mid_rst_in_ready", 128'(bus_if.in_ready), 128'(1'b1));
        check("mid_rst_res", bus_if.res, 128'(0));
        check("mid_rst_out_valid", 128'(bus_if.out_valid), 128'(1'b0));
        check("mid_rst_busy", 128'(bus_if.busy), 128'(1'b0));
        saw_valid = 0;
        for (int t = 0; t < 70; t++) begin
            if (bus_if.out_valid) saw_valid++;
            tick();
        end
        check("mid_rst_no_valid", 128'(saw_valid), 128'(0));
        run("after_rst", rand128(), rand128());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mat_mult_seq.md
# mat_mult_seq

Sequential 4x4 matrix-multiply engine for the graphics transform path: computes Res = A*B on 8-bit elements with a single shared multiply-accumulate unit instead of 64 parallel multipliers. It accepts an operand pair over a valid/ready handshake, steps through the i/j/k loop under an FSM, and presents the 128-bit result over a second valid/ready handshake. It replaces the combinational multiplier wherever area matters more than latency, for example the per-frame sprite transform set-up.

## Interface
- ELEM_W, 8: element width in bits. Only 8 is supported; the port widths are 16*ELEM_W.
- ACC_W, 18: accumulator width. 4*255*255 = 260100 fits in 18 bits, so the accumulator never overflows.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand pair on a/b is valid.
- in_ready  out  1  engine idle and able to accept operands.
- a  in  128  matrix A, row-major; a[127:120] is A[0][0], a[7:0] is A[3][3].
- b  in  128  matrix B, same packing as a.
- out_valid  out  1  res holds a complete product.
- out_ready  in  1  consumer takes the result.
- res  out  128  product, same packing as a.
- busy  out  1  high in CALC and DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, register a and b into internal operand registers, clear the i/j/k counters and the accumulator, then go to CALC.
  - CALC: one MAC per cycle, acc += A[i][k]*B[k][j], with both operands read from the registered copies.
    - k increments every cycle.
    - When k==3, write Res[i][j] from the final sum (acc + product of this cycle) into the result register, zero acc, wrap k to 0 and advance j, then i.
    - After element [3][3] is written, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Loop order: i outer, j middle, k inner. Elements are written row-major, [0][0] first.
- Element result: the low 8 bits of the 18-bit sum (mod 256), unless MAT_SAT_EN is defined (see Configuration).
- a and b may change after acceptance without affecting the result in flight.
- in_valid in any state other than IDLE is ignored; in_ready is low there.
- res is the result register and is updated element by element during CALC. Its contents are defined only while out_valid=1. It is held stable for as long as out_valid=1 and out_ready=0.
- rst in any state, mid-CALC included: the next state is IDLE, the counters, acc and res are cleared, and the partial result is discarded with no out_valid pulse.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, res=0.
- Handshake accepted at edge N → CALC during cycles N+1..N+64 → out_valid=1 from cycle N+65.
- If out_ready is high in the first DONE cycle, the engine is back in IDLE at N+66 (in_ready=1). Minimum issue interval is 66 cycles.
- in_ready and out_valid are decoded combinationally from the state register. No output depends combinationally on in_valid or out_ready.
- DONE with out_ready=0 holds indefinitely. There is no timeout.
- rst has priority over every handshake in the same cycle.

## Configuration
- MAT_SAT_EN:
  - Defined: each element is min(sum, 255) (unsigned saturation).
  - Undefined: each element is sum[7:0], i.e. wrap-around, bit-exact with the existing combinational multiplier.
  - Latency is identical in both builds.

## Structure
- Shared package mat_pkg holds:
  - constants MAT_N=4, MAT_ELEM_W=8, MAT_ACC_W=18;
  - the state enum {IDLE, CALC, DONE};
  - a function mapping (row, col) to the bit offset of the element in the packed vector, (15-(4*row+col))*8.
- Sub-module mat_mac: an 8x8 unsigned multiplier plus 18-bit accumulator, with clear and enable inputs. It exposes the next sum combinationally so the k==3 write-back needs no extra cycle.
- The FSM, counters and operand/result registers live in mat_mult_seq.

## Test plan
- Reset → in_ready=1, out_valid=0, busy=0, res=0 on the first cycle after rst falls.
- A=identity (0x01 on the diagonal), B=elements 1..16 row-major → res=B; out_valid asserts exactly 65 cycles after the accepting edge.
- A all 0x02, B all 0x03 → every element 0x18.
- A all 0xFF, B all 0xFF → every element 0x04 without MAT_SAT_EN, 0xFF with it.
- out_ready held low for 10 cycles after out_valid → res stable, in_ready=0, and an in_valid pulse in this window is ignored; after out_ready=1, in_ready=1 on the next cycle.
- rst asserted 30 cycles into CALC → next cycle IDLE, res=0, out_valid stays 0. A new operand pair accepted afterwards gives the correct product.
